// File: rtl/gpa_fhdo_pkg.sv
// Shared constants and types for the GPA-FHDO DAC emulator: register map,
// frame geometry and the frame FSM encoding.
package gpa_fhdo_pkg;

  localparam int FRAME_BITS = 24;
  localparam logic [4:0] BIT_CNT_SAT = 5'd25;

  localparam logic [15:0] DEV_ID        = 16'h2150;
  localparam logic [3:0]  SOFT_RST_CODE = 4'b1010;

  localparam logic [3:0] ADDR_NOP       = 4'h0;
  localparam logic [3:0] ADDR_DEVICE_ID = 4'h1;
  localparam logic [3:0] ADDR_SYNC      = 4'h2;
  localparam logic [3:0] ADDR_CONFIG    = 4'h3;
  localparam logic [3:0] ADDR_GAIN      = 4'h4;
  localparam logic [3:0] ADDR_TRIGGER   = 4'h5;
  localparam logic [3:0] ADDR_DAC0      = 4'h8;
  localparam logic [3:0] ADDR_DAC1      = 4'h9;
  localparam logic [3:0] ADDR_DAC2      = 4'hA;
  localparam logic [3:0] ADDR_DAC3      = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } frame_state_t;

endpackage

// File: rtl/gpa_fhdo_dac_emu_if.sv
// SPI + load-strobe bundle between the GPA-FHDO master and the DAC emulator.
// No valid/ready handshake: the master owns sclk/csn timing, the slave only answers on sdo.
interface gpa_fhdo_dac_emu_if;
  logic sclk_i;
  logic csn_i;
  logic sdi_i;
  logic ldacn_i;
  logic sdo_o;

  modport master (output sclk_i, output csn_i, output sdi_i, output ldacn_i, input sdo_o);
  modport slave  (input sclk_i, input csn_i, input sdi_i, input ldacn_i, output sdo_o);
endinterface

// File: rtl/gpa_fhdo_sync_edge.sv
// Multi-stage synchronizer for one async line with single-clk rise/fall pulses.
module gpa_fhdo_sync_edge
  import gpa_fhdo_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= {SYNC_STAGES{INIT}};
      prev <= INIT;
    end else begin
      sr   <= (sr << 1) | SYNC_STAGES'(din);
      prev <= sr[SYNC_STAGES-1];
    end
  end

  assign sync = sr[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/gpa_fhdo_dac_emu.sv
// Emulates the GPA-FHDO quad DAC SPI slave: 24-bit frames, buffered/synchronous
// channel updates via LDAC or TRIGGER, and readback of the previous read command.
module gpa_fhdo_dac_emu
  import gpa_fhdo_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  gpa_fhdo_dac_emu_if.slave   spi,
  output logic [15:0]         vout0_o,
  output logic [15:0]         vout1_o,
  output logic [15:0]         vout2_o,
  output logic [15:0]         vout3_o,
  output logic                frame_err_o,
  output frame_state_t        dbg_state
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic csn_sync, csn_rise, csn_fall;
  logic ldacn_sync, ldacn_rise, ldac_fall;

  gpa_fhdo_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(spi.sclk_i),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );
  gpa_fhdo_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_csn (
    .clk(clk), .rst(rst), .din(spi.csn_i),
    .sync(csn_sync), .rise(csn_rise), .fall(csn_fall)
  );
  gpa_fhdo_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_ldacn (
    .clk(clk), .rst(rst), .din(spi.ldacn_i),
    .sync(ldacn_sync), .rise(ldacn_rise), .fall(ldac_fall)
  );

  logic [SYNC_STAGES-1:0] sdi_sr;
  logic                   sdi_sync;
  assign sdi_sync = sdi_sr[SYNC_STAGES-1];

  // A csn held low across reset would otherwise look like a fresh falling edge
  // once the synchronizer flushes; only arm after csn has been seen high.
  logic [SYNC_STAGES:0] flush_sr;
  logic                 armed;

  frame_state_t  state_q, state_n;
  logic [4:0]    bit_cnt_q;
  logic [23:0]   rx_sr_q, tx_sr_q;
  logic          start_frame, commit;

  logic          frame_rw;
  logic [3:0]    frame_addr;
  logic [15:0]   frame_data;

  logic [3:0][15:0] dac_buf_q, dac_buf_n, vout_q, vout_n;
  logic [15:0]      sync_q, sync_n, config_q, config_n, gain_q, gain_n;
  logic [23:0]      rd_word_q, rd_word_n;
  logic             rd_pending_q, rd_pending_n;
  logic [15:0]      rd_data;
  logic             soft_rst, trig_load;

  assign frame_rw   = rx_sr_q[23];
  assign frame_addr = rx_sr_q[19:16];
  assign frame_data = rx_sr_q[15:0];

  assign start_frame = (state_q == ST_IDLE) && csn_fall && armed;
  assign commit      = (state_q == ST_COMMIT) && (bit_cnt_q == 5'(FRAME_BITS));
  assign frame_err_o = (state_q == ST_COMMIT) && (bit_cnt_q != 5'(FRAME_BITS));

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:   if (start_frame) state_n = ST_SHIFT;
      ST_SHIFT:  if (csn_rise) state_n = ST_COMMIT;
      ST_COMMIT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      sdi_sr    <= '0;
      flush_sr  <= '0;
      armed     <= 1'b0;
    end else begin
      state_q  <= state_n;
      sdi_sr   <= (sdi_sr << 1) | SYNC_STAGES'(spi.sdi_i);
      flush_sr <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
      armed    <= armed | (flush_sr[SYNC_STAGES] & csn_sync);
      if (start_frame) begin
        bit_cnt_q <= '0;
        tx_sr_q   <= rd_pending_q ? rd_word_q : '0;
      end else if (state_q == ST_SHIFT) begin
        if (sclk_fall) begin
          rx_sr_q <= {rx_sr_q[22:0], sdi_sync};
          if (bit_cnt_q != BIT_CNT_SAT) bit_cnt_q <= bit_cnt_q + 5'd1;
        end
        if (csn_rise)       tx_sr_q <= '0;
        else if (sclk_rise) tx_sr_q <= {tx_sr_q[22:0], 1'b0};
      end
    end
  end

  assign spi.sdo_o = tx_sr_q[23];

  // Register file: buffer write is resolved before any LDAC/TRIGGER load in the same clk.
  always_comb begin
    dac_buf_n    = dac_buf_q;
    vout_n       = vout_q;
    sync_n       = sync_q;
    config_n     = config_q;
    gain_n       = gain_q;
    rd_word_n    = rd_word_q;
    rd_pending_n = rd_pending_q;
    soft_rst     = 1'b0;
    trig_load    = 1'b0;
    rd_data      = '0;

    case (frame_addr)
      ADDR_DEVICE_ID: rd_data = DEV_ID;
      ADDR_SYNC:      rd_data = sync_q;
      ADDR_CONFIG:    rd_data = config_q;
      ADDR_GAIN:      rd_data = gain_q;
      ADDR_DAC0, ADDR_DAC1, ADDR_DAC2, ADDR_DAC3: rd_data = dac_buf_q[frame_addr[1:0]];
      default:        rd_data = '0;
    endcase

    if (start_frame) rd_pending_n = 1'b0;

    if (commit) begin
      if (frame_rw) begin
        rd_word_n    = {1'b1, 3'b000, frame_addr, rd_data};
        rd_pending_n = 1'b1;
      end else begin
        case (frame_addr)
          ADDR_SYNC:   sync_n   = frame_data;
          ADDR_CONFIG: config_n = frame_data;
          ADDR_GAIN:   gain_n   = frame_data;
          ADDR_TRIGGER: begin
            if (frame_data[3:0] == SOFT_RST_CODE) soft_rst  = 1'b1;
            else if (frame_data[4])               trig_load = 1'b1;
          end
          ADDR_DAC0, ADDR_DAC1, ADDR_DAC2, ADDR_DAC3: begin
            dac_buf_n[frame_addr[1:0]] = frame_data;
            if (!sync_q[frame_addr[1:0]]) vout_n[frame_addr[1:0]] = frame_data;
          end
          default: ;
        endcase
      end
    end

    for (int ch = 0; ch < 4; ch++) begin
      if ((ldac_fall || trig_load) && sync_q[ch]) vout_n[ch] = dac_buf_n[ch];
    end

    if (soft_rst) begin
      dac_buf_n    = '0;
      vout_n       = '0;
      sync_n       = '0;
      config_n     = '0;
      gain_n       = '0;
      rd_word_n    = '0;
      rd_pending_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_buf_q    <= '0;
      vout_q       <= '0;
      sync_q       <= '0;
      config_q     <= '0;
      gain_q       <= '0;
      rd_word_q    <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      dac_buf_q    <= dac_buf_n;
      vout_q       <= vout_n;
      sync_q       <= sync_n;
      config_q     <= config_n;
      gain_q       <= gain_n;
      rd_word_q    <= rd_word_n;
      rd_pending_q <= rd_pending_n;
    end
  end

  assign vout0_o   = vout_q[0];
  assign vout1_o   = vout_q[1];
  assign vout2_o   = vout_q[2];
  assign vout3_o   = vout_q[3];
  assign dbg_state = state_q;

  logic unused_sigs;
  assign unused_sigs = &{1'b0, sclk_sync, ldacn_sync, ldacn_rise, rx_sr_q[22:20]};

endmodule
